// File: rtl/enc_pkg.sv
// Shared constants for the convolutional encoder/packer: code-rate codes,
// K=3 generator taps, frame geometry and the control state encoding.
package enc_pkg;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  // Generator taps applied to {b, s1, s2}: octal 7 and octal 5
  localparam logic [2:0] GEN_7 = 3'b111;
  localparam logic [2:0] GEN_5 = 3'b101;

  localparam int         FRAME_W   = 16;
  localparam logic [3:0] BITS_R2   = 4'd8;   // 16 symbols per frame
  localparam logic [3:0] BITS_R3   = 4'd5;   // 15 symbols, bit 0 left at zero
  localparam logic [3:0] PTR_INIT  = 4'd15;
  localparam logic [1:0] TAIL_BITS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    TAIL,
    SEND,
    DONE
  } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// K=3 convolutional encoder core: two-bit shift register plus symbol
// generation. Symbols come out MSB-first in o_sym; at rate 1/2 only the
// upper two bits are meaningful and bit 0 is driven zero.
module conv_enc_core
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_adv,
  input  logic       i_bit,
  input  logic       i_rate,
  output logic [2:0] o_sym
);

  logic       r_s1;
  logic       r_s2;
  logic [2:0] w_reg;
  logic       w_g7;
  logic       w_g5;

  // Shift the consumed bit into the encoder state; a new message clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else if (i_clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else if (i_adv) begin
      r_s1 <= i_bit;
      r_s2 <= r_s1;
    end
  end

  assign w_reg = {i_bit, r_s1, r_s2};
  assign w_g7  = ^(w_reg & GEN_7);
  assign w_g5  = ^(w_reg & GEN_5);
  assign o_sym = (i_rate == CODE_RATE_3) ? {w_g7, w_g7, w_g5} : {w_g7, w_g5, 1'b0};

endmodule

// File: rtl/conv_enc_pack.sv
// Convolutional encoder with 16-bit frame packer and valid/ready output.
// Optional feature: define ENC_TAIL_EN to append two zero tail bits on flush.
module conv_enc_pack
  import enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_e,
  input  logic        i_code_rate,
  input  logic        i_start,
  input  logic        i_bit,
  input  logic        i_bit_valid,
  output logic        o_bit_ready,
  input  logic        i_flush,
  output logic [15:0] o_data_frame,
  output logic        o_frame_valid,
  input  logic        i_frame_ready,
  output logic        o_eof
);

`ifdef ENC_TAIL_EN
  localparam logic [1:0] TAIL_INIT = TAIL_BITS;
`else
  localparam logic [1:0] TAIL_INIT = 2'd0;
`endif

  enc_state_e  r_state;
  logic        r_rate;
  logic [3:0]  r_ptr;
  logic [3:0]  r_nbits;
  logic [15:0] r_frame;
  logic        r_valid;
  logic        r_eof;
  logic        r_flush;      // flush requested; message ends after pending data
  logic [1:0]  r_tail_left;  // tail bits still to encode

  logic        w_start;
  logic        w_accept;
  logic        w_wr;
  logic        w_bin;
  logic [2:0]  w_sym;
  logic [15:0] w_sym_vec;
  logic [3:0]  w_step;
  logic [3:0]  w_bpf;
  logic        w_full;

  assign o_bit_ready   = (r_state == FILL) && !r_flush;
  assign o_data_frame  = r_frame;
  assign o_frame_valid = r_valid;
  assign o_eof         = r_eof;

  assign w_start   = en_e && i_start && (r_state == IDLE || r_state == DONE);
  assign w_accept  = en_e && i_bit_valid && o_bit_ready;
  assign w_wr      = w_accept || (en_e && r_state == TAIL);
  assign w_bin     = (r_state == TAIL) ? 1'b0 : i_bit;
  assign w_step    = (r_rate == CODE_RATE_3) ? 4'd3 : 4'd2;
  assign w_bpf     = (r_rate == CODE_RATE_3) ? BITS_R3 : BITS_R2;
  assign w_full    = (r_nbits + 4'd1) == w_bpf;
  // Align the symbol group so its first symbol lands on the write pointer
  assign w_sym_vec = {w_sym, 13'd0} >> (PTR_INIT - r_ptr);

  conv_enc_core u_core (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_adv  (w_wr),
    .i_bit  (w_bin),
    .i_rate (r_rate),
    .o_sym  (w_sym)
  );

  // Control FSM: fill frames with symbols, hand them off, finish the message
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rate      <= CODE_RATE_2;
      r_ptr       <= PTR_INIT;
      r_nbits     <= 4'd0;
      r_frame     <= 16'd0;
      r_valid     <= 1'b0;
      r_eof       <= 1'b0;
      r_flush     <= 1'b0;
      r_tail_left <= 2'd0;
    end else if (en_e) begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state     <= FILL;
            r_rate      <= i_code_rate;
            r_ptr       <= PTR_INIT;
            r_nbits     <= 4'd0;
            r_frame     <= 16'd0;
            r_eof       <= 1'b0;
            r_flush     <= 1'b0;
            r_tail_left <= 2'd0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_frame <= r_frame | w_sym_vec;
            r_ptr   <= r_ptr - w_step;
            r_nbits <= r_nbits + 4'd1;
            // Flush alongside a bit: the bit goes in now, flush acts next
            if (i_flush) begin
              r_flush     <= 1'b1;
              r_tail_left <= TAIL_INIT;
            end
            if (w_full) begin
              r_state <= SEND;
              r_valid <= 1'b1;
            end
          end else if (r_flush || i_flush) begin
            r_flush <= 1'b1;
`ifdef ENC_TAIL_EN
            r_tail_left <= TAIL_BITS;
            r_state     <= TAIL;
`else
            if (r_nbits != 4'd0) begin
              r_state <= SEND;
              r_valid <= 1'b1;
            end else begin
              r_state <= DONE;
              r_eof   <= 1'b1;
            end
`endif
          end
        end
        TAIL: begin
          r_frame     <= r_frame | w_sym_vec;
          r_ptr       <= r_ptr - w_step;
          r_nbits     <= r_nbits + 4'd1;
          r_tail_left <= r_tail_left - 2'd1;
          if (r_tail_left == 2'd1 || w_full) begin
            r_state <= SEND;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          if (i_frame_ready) begin
            r_valid <= 1'b0;
            r_frame <= 16'd0;
            r_ptr   <= PTR_INIT;
            r_nbits <= 4'd0;
            r_rate  <= i_code_rate;  // next frame starts here
            if (!r_flush) begin
              r_state <= FILL;
            end else if (r_tail_left != 2'd0) begin
              r_state <= TAIL;
            end else begin
              r_state <= DONE;
              r_eof   <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_enc_pack.md
CONV_ENC_PACK -- requirements
Module: conv_enc_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port en_e, input, 1 bit: global enable; low freezes all state and outputs.
REQ-004 SHALL have port i_code_rate, input, 1 bit: CODE_RATE_2 (rate 1/2) or CODE_RATE_3 (rate 1/3).
REQ-005 SHALL have port i_start, input, 1 bit: pulse that begins a new message.
REQ-006 SHALL have ports i_bit, input, 1 bit, and i_bit_valid, input, 1 bit: information bit and qualifier.
REQ-007 SHALL have port o_bit_ready, output, 1 bit: block accepts i_bit this cycle.
REQ-008 SHALL have port i_flush, input, 1 bit: end-of-message request.
REQ-009 SHALL have ports o_data_frame, output, 16 bits, and o_frame_valid, output, 1 bit: packed encoded frame and qualifier.
REQ-010 SHALL have port i_frame_ready, input, 1 bit: downstream accepts the frame.
REQ-011 SHALL have port o_eof, output, 1 bit: message fully emitted.

Function
REQ-012 SHALL use a K=3 encoder, state (s1,s2) = last two bits; rate 1/2 generators (7,5): c0=b^s1^s2, c1=b^s2; rate 1/3 generators (7,7,5): c0=c1=b^s1^s2, c2=b^s2.
REQ-013 SHALL pack symbols MSB-first: first symbol at bit 15, c0 at the highest index of its group; write pointer starts at 15, decrements by 2 or 3.
REQ-014 SHALL hold 8 bits (16 symbols) per frame at rate 1/2 and 5 bits (15 symbols) at rate 1/3, bit 0 forced 0.
REQ-015 SHALL latch i_code_rate at frame start; changes mid-frame are ignored until the next frame.
REQ-016 SHALL implement states IDLE, FILL, TAIL, SEND, DONE; IDLE/DONE -> FILL on i_start; FILL -> SEND when frame full; FILL -> TAIL on i_flush; TAIL -> SEND when tail complete or frame full; SEND -> FILL/TAIL/DONE on handshake.
REQ-017 SHALL accept a bit when en_e & i_bit_valid & o_bit_ready; o_bit_ready high only in FILL.
REQ-018 SHALL assert o_frame_valid the cycle after the last symbol of a frame is written; o_data_frame stable while o_frame_valid high and i_frame_ready low.
REQ-019 SHALL complete handshake on o_frame_valid & i_frame_ready; o_frame_valid low the following cycle.
REQ-020 SHALL on flush emit any partial frame with unwritten bits zero; if frame empty and no tail pending, go directly to DONE without emitting.
REQ-021 SHALL, on i_bit_valid and i_flush in the same cycle, accept the bit first and begin flush next cycle.
REQ-022 SHALL, if the tail fills a frame, emit it and continue the remaining tail into the next frame.
REQ-023 SHALL assert o_eof in DONE, held until i_start; i_start clears (s1,s2), pointer and o_eof.
REQ-024 SHALL ignore i_start outside IDLE/DONE.

Reset
REQ-025 SHALL on rst low: state IDLE, (s1,s2)=00, pointer 15, o_data_frame=0, o_frame_valid=0, o_bit_ready=0, o_eof=0, immediately, including mid-frame (partial frame discarded).

Configuration
REQ-026 SHALL, with ENC_TAIL_EN defined, append two zero tail bits on flush, returning encoder state to 00.
REQ-027 SHALL, without ENC_TAIL_EN, skip TAIL (FILL -> SEND or DONE directly on flush) and append no tail symbols.

Structure
REQ-028 SHALL place CODE_RATE_2/3, generator polynomials, frame width 16, bits-per-frame constants and state enum in shared package enc_pkg.
REQ-029 SHALL instantiate sub-module conv_enc_core (shift register + symbol generation, 3-bit symbol output).

Verification
REQ-030 Rate 1/2, start, bits 1,0,1,1,0,0,0,0, ready=1 -> one frame 0xE170, o_frame_valid one cycle after 8th bit.
REQ-031 Rate 1/3, bits 1,0,1,1,0 -> frame 0xF812.
REQ-032 Rate 1/2, bits 1,1 then flush, ENC_TAIL_EN -> 0xD700 then o_eof; without macro -> 0xD000 then o_eof.
REQ-033 Full frame with i_frame_ready low 5 cycles -> o_data_frame held, o_bit_ready low, no bit lost after release.
REQ-034 rst low mid-frame after 3 bits -> all outputs 0 immediately; restart yields same frames as clean run.
REQ-035 en_e low during FILL and SEND for 4 cycles -> no state change, outputs held.
